memory_bus_controller: RTL and testbench



---
 rtl/memory_bus_controller.sv | 169 ++++++++++++++++
 tb/tb_memory_bus_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_controller.sv
// Memory-side slave for the CPU core: internal word RAM, a 256-byte peripheral
// window forwarded to the per_* port, and error responses for bad accesses.
module memory_bus_controller #(
    parameter int          RAM_WORDS      = 1024,
    parameter int          RAM_LATENCY    = 1,
    parameter logic [31:0] PERIPH_BASE    = 32'h4000_0000,
    parameter int          PERIPH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_write,
    input  logic        cpu_req,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_error,
    output logic [7:0]  per_addr,
    output logic [31:0] per_wdata,
    output logic        per_write,
    output logic        per_valid,
    input  logic [31:0] per_rdata,
    input  logic        per_ready
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;
    localparam logic [3:0]  LAT       = 4'(RAM_LATENCY);
    localparam logic [7:0]  TMO_LAST  = 8'(PERIPH_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RAM_WAIT, PER_REQ, RESP, ERR} state_t;

    state_t          state_reg, state_next;
    logic [3:0]      wait_cnt_reg;
    logic [7:0]      tmo_cnt_reg;
    logic            write_reg;
    logic [31:0]     wdata_reg;
    logic [AW-1:0]   ram_idx_reg;
    logic [31:0]     rdata_reg;
    logic            sel_ram_reg;
    logic [31:0]     ram_rd_reg;
    logic [7:0]      per_addr_reg;
    logic [31:0]     per_wdata_reg;
    logic            per_write_reg;
    logic            per_valid_reg;
    logic            ram_we, ram_re;
    logic            misaligned, hit_ram, hit_per;

    logic [31:0] ram [0:RAM_WORDS-1];

    // Unsigned 33-bit compare so high addresses never alias into a small RAM.
    assign misaligned = |cpu_addr[1:0];
    assign hit_ram    = {1'b0, cpu_addr} < RAM_BYTES;
    assign hit_per    = cpu_addr[31:8] == PERIPH_BASE[31:8];

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        cpu_ready  = 1'b0;
        cpu_error  = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (misaligned)   state_next = ERR;
                    else if (hit_ram) state_next = RAM_WAIT;
                    else if (hit_per) state_next = PER_REQ;
                    else              state_next = ERR;
                end
            end
            RAM_WAIT: begin
                if (wait_cnt_reg == 4'd1) begin
                    state_next = RESP;
                    // A reset on the commit edge must suppress the write.
                    ram_we     = write_reg & ~rst;
                    ram_re     = ~write_reg;
                end
            end
            PER_REQ: begin
                if (per_ready)                    state_next = RESP;
                else if (tmo_cnt_reg == TMO_LAST) state_next = ERR;
            end
            RESP: begin
                cpu_ready  = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                cpu_ready  = 1'b1;
                cpu_error  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            write_reg     <= 1'b0;
            wdata_reg     <= '0;
            ram_idx_reg   <= '0;
            rdata_reg     <= '0;
            sel_ram_reg   <= 1'b0;
            per_addr_reg  <= '0;
            per_wdata_reg <= '0;
            per_write_reg <= 1'b0;
            per_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        write_reg    <= cpu_write;
                        wdata_reg    <= cpu_wdata;
                        ram_idx_reg  <= cpu_addr[AW+1:2];
                        wait_cnt_reg <= LAT;
                        tmo_cnt_reg  <= '0;
                        if (state_next == PER_REQ) begin
                            per_valid_reg <= 1'b1;
                            per_addr_reg  <= cpu_addr[7:0];
                            per_wdata_reg <= cpu_wdata;
                            per_write_reg <= cpu_write;
                        end
                    end
                end
                RAM_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    if (ram_re) sel_ram_reg <= 1'b1;
                end
                PER_REQ: begin
                    if (per_ready) begin
                        per_valid_reg <= 1'b0;
                        if (!per_write_reg) begin
                            rdata_reg   <= per_rdata;
                            sel_ram_reg <= 1'b0;
                        end
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                        if (state_next == ERR) per_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Error responses always present zero read data.
            if (state_next == ERR) begin
                rdata_reg   <= '0;
                sel_ram_reg <= 1'b0;
            end
        end
    end

    // RAM read register lives beside the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx_reg] <= wdata_reg;
        if (ram_re) ram_rd_reg <= ram[ram_idx_reg];
    end

    assign cpu_rdata = sel_ram_reg ? ram_rd_reg : rdata_reg;
    assign per_addr  = per_addr_reg;
    assign per_wdata = per_wdata_reg;
    assign per_write = per_write_reg;
    assign per_valid = per_valid_reg;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed bench for memory_bus_controller: responses are checked against a
// queue of expected results pushed when each request is driven.
module tb_memory_bus_controller;

    localparam logic [31:0] PB = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_write = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_error;
    logic [7:0]  per_addr;
    logic [31:0] per_wdata;
    logic        per_write;
    logic        per_valid;
    logic [31:0] per_rdata = '0;
    logic        per_ready = 1'b0;

    memory_bus_controller dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_write (cpu_write),
        .cpu_req   (cpu_req),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_error (cpu_error),
        .per_addr  (per_addr),
        .per_wdata (per_wdata),
        .per_write (per_write),
        .per_valid (per_valid),
        .per_rdata (per_rdata),
        .per_ready (per_ready)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] last_rd = '0;

    int          per_delay = 0;
    logic [31:0] per_data = '0;
    int          pv_cnt = 0;
    int          pv_last = 0;
    logic [7:0]  per_addr_seen = '0;
    logic        per_write_seen = 1'b0;
    logic [31:0] per_wdata_seen = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 32'(cpu_ready), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %s: rdata=%h error=%b cycle=%0d", e.tag, cpu_rdata, cpu_error, cyc);
                chk({e.tag, "_rdata"}, cpu_rdata, e.rd);
                chk({e.tag, "_error"}, 32'(cpu_error), 32'(e.err));
                chk({e.tag, "_time"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    // Peripheral model: asserts per_ready on the per_delay-th per_valid cycle.
    always @(negedge clk) begin
        if (per_valid) begin
            pv_cnt++;
            pv_last        = pv_cnt;
            per_addr_seen  = per_addr;
            per_write_seen = per_write;
            per_wdata_seen = per_wdata;
            per_ready      = (pv_cnt == per_delay);
            per_rdata      = per_ready ? per_data : (32'hDEAD_0000 | 32'(pv_cnt));
        end else begin
            pv_cnt    = 0;
            per_ready = 1'b0;
        end
    end

    task automatic push_exp(input string tag, input logic [31:0] rd, input logic w,
                            input logic err, input int lat);
        exp_t e;
        e.rd  = (w && !err) ? last_rd : rd;
        last_rd = e.rd;
        e.err = err;
        e.due = cyc + lat;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [31:0] rd, input logic err, input int lat);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = w;
        cpu_req   = 1'b1;
        push_exp(tag, rd, w, err, lat);
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_addr  = 32'h6;
        cpu_wdata = ~d;
        cpu_write = ~w;
        drain(tag);
    endtask

    logic [31:0] b_addr [5] = '{32'h10, 32'h3, 32'h14, 32'hFFFF_FFFC, 32'hFFC};
    logic [31:0] b_rd   [5] = '{32'hDEAD_BEEF, 32'h0, 32'h1111_2222, 32'h0, 32'h0F0F_0F0F};
    logic        b_err  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd0);
        chk("rst_error", 32'(cpu_error), 32'd0);
        chk("rst_per_valid", 32'(per_valid), 32'd0);
        chk("rst_per_addr", 32'(per_addr), 32'd0);
        rst = 1'b0;

        txn("st0",   32'h0,  32'h0000_600D, 1'b1, 32'h0, 1'b0, 2);
        txn("st14",  32'h14, 32'h1111_2222, 1'b1, 32'h0, 1'b0, 2);
        txn("st10",  32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 2);
        txn("ld10",  32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        txn("ld14",  32'h14, 32'h0, 1'b0, 32'h1111_2222, 1'b0, 2);
        txn("st18",  32'h18, 32'h77, 1'b1, 32'h0, 1'b0, 2);

        pv_last = 0;
        txn("ld_mis",   32'h2, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        txn("st_unmap", 32'h2000_0000, 32'h1234, 1'b1, 32'h0, 1'b1, 1);
        chk("unmap_no_per_valid", 32'(pv_last), 32'd0);
        txn("st_mis",   32'h12, 32'hBAD, 1'b1, 32'h0, 1'b1, 1);
        txn("st_ffc",   32'hFFC, 32'h0F0F_0F0F, 1'b1, 32'h0, 1'b0, 2);
        txn("st_wrap",  32'hFFFF_FFFC, 32'h00BA_DBAD, 1'b1, 32'h0, 1'b1, 1);
        txn("st_end",   32'h1000, 32'hBAD1, 1'b1, 32'h0, 1'b1, 1);
        txn("ld0",      32'h0, 32'h0, 1'b0, 32'h0000_600D, 1'b0, 2);
        txn("ld10b",    32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        txn("ldffc",    32'hFFC, 32'h0, 1'b0, 32'h0F0F_0F0F, 1'b0, 2);

        per_delay = 3; per_data = 32'h55; pv_last = 0;
        txn("per_ld", PB + 32'h8, 32'h0, 1'b0, 32'h55, 1'b0, 4);
        chk("per_ld_valid_cycles", 32'(pv_last), 32'd3);
        chk("per_ld_addr", 32'(per_addr_seen), 32'h8);
        chk("per_ld_write", 32'(per_write_seen), 32'd0);

        per_delay = 0; pv_last = 0;
        txn("per_tmo", PB, 32'hA1B2_C3D4, 1'b1, 32'h0, 1'b1, 17);
        chk("per_tmo_valid_cycles", 32'(pv_last), 32'd16);
        chk("per_tmo_write", 32'(per_write_seen), 32'd1);
        chk("per_tmo_wdata", per_wdata_seen, 32'hA1B2_C3D4);

        per_delay = 16; per_data = 32'hCAFE; pv_last = 0;
        txn("per_last", PB + 32'h4, 32'h0, 1'b0, 32'hCAFE, 1'b0, 17);
        chk("per_last_valid_cycles", 32'(pv_last), 32'd16);

        pv_last = 0;
        txn("per_out", PB + 32'h100, 32'h0, 1'b0, 32'h0, 1'b1, 1);
        chk("per_out_no_valid", 32'(pv_last), 32'd0);
        per_delay = 1; per_data = 32'h99;
        txn("per_top", PB + 32'hFC, 32'h5555, 1'b0, 32'h99, 1'b0, 2);
        chk("per_top_addr", 32'(per_addr_seen), 32'hFC);

        // Reset lands on the RAM commit edge of a store to 0x10.
        @(negedge clk);
        cpu_addr = 32'h10; cpu_wdata = 32'h0BAD_F00D; cpu_write = 1'b1; cpu_req = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_rdata", cpu_rdata, 32'd0);
        chk("midrst_ready", 32'(cpu_ready), 32'd0);
        chk("midrst_error", 32'(cpu_error), 32'd0);
        chk("midrst_per_valid", 32'(per_valid), 32'd0);
        chk("midrst_per_write", 32'(per_write), 32'd0);
        chk("midrst_per_addr", 32'(per_addr), 32'd0);
        chk("midrst_per_wdata", per_wdata, 32'd0);
        rst = 1'b0;
        last_rd = '0;
        txn("ld10_after_rst", 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);

        // Request held high; decoy addresses fill the cycles the DUT must ignore.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = b_addr[k];
            push_exp("busy", b_rd[k], 1'b0, b_err[k], b_err[k] ? 1 : 2);
            for (int j = 0; j < (b_err[k] ? 1 : 2); j++) begin
                @(negedge clk);
                cpu_addr = 32'h6;
                if (k == 4 && j == 1) cpu_req = 1'b0;
            end
        end
        drain("busy");
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1);
    end

endmodule
